// File: rtl/dm_access_pkg.sv
// dm_access_pkg: shared definitions for the data-memory access unit.
//   - dm_op_e        : 4-bit load/store operation codes
//   - is_store()     : store predicate (op[3])
//   - is_valid_op()  : true for the eight defined load/store codes
//   - default address-error exception codes
package dm_access_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LW  = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LB  = 4'd4,
    OP_LBU = 4'd5,
    OP_SW  = 4'd9,
    OP_SH  = 4'd10,
    OP_SB  = 4'd11
  } dm_op_e;

  localparam int         DM_ADDR_WIDTH_DEF = 13;
  localparam logic [4:0] EXC_ADEL_DEF      = 5'd4;
  localparam logic [4:0] EXC_ADES_DEF      = 5'd5;

  function automatic logic is_store(input logic [3:0] op);
    return op[3];
  endfunction

  function automatic logic is_valid_op(input logic [3:0] op);
    logic ok;
    case (op)
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU,
      OP_SW, OP_SH, OP_SB: ok = 1'b1;
      default:             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dm_load_extend.sv
// dm_load_extend: combinational load-data extraction.
//   op_i   : load operation code
//   off_i  : byte offset within the word (addr[1:0])
//   word_i : word read from data memory
//   data_o : selected byte/half/word, sign- or zero-extended; 0 for non-loads
module dm_load_extend
  import dm_access_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half = off_i[1] ? word_i[31:16] : word_i[15:0];
    case (off_i)
      2'd0:    byte_sel = word_i[7:0];
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      default: byte_sel = word_i[31:24];
    endcase

    case (op_i)
      OP_LW:   data_o = word_i;
      OP_LH:   data_o = {{16{half[15]}}, half};
      OP_LHU:  data_o = {16'h0000, half};
      OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data_o = {24'h000000, byte_sel};
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_access_unit.sv
// dm_access_unit: MEM-stage initiator for the data-memory word port.
// Two-stage pipeline: S1 holds the accepted request and drives the memory
// port; S2 holds the response (extended load data / exception code).
//   clk, reset                 : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake
//   req_op/addr/wdata/pc       : request payload
//   dm_pc/addr/wdata/we        : data-memory port, driven from S1
//   dm_rdata                   : combinational read word for dm_addr
//   resp_valid/resp_ready      : response handshake
//   resp_rdata/exc/pc          : response payload
module dm_access_unit
  import dm_access_pkg::*;
#(
  parameter int         DM_ADDR_WIDTH = DM_ADDR_WIDTH_DEF,
  parameter logic [4:0] EXC_ADEL      = EXC_ADEL_DEF,
  parameter logic [4:0] EXC_ADES      = EXC_ADES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic [31:0] dm_pc,
  output logic [29:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_we,
  input  logic [31:0] dm_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_exc,
  output logic [31:0] resp_pc
);

  // S1 registers
  logic        s1_valid_q, s1_valid_d;
  logic [3:0]  s1_op_q;
  logic [31:0] s1_addr_q;
  logic [31:0] s1_wdata_q;
  logic [31:0] s1_pc_q;

  // S2 registers
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_rdata_q, s2_rdata_d;
  logic [4:0]  s2_exc_q, s2_exc_d;
  logic [31:0] s2_pc_q;

  logic        s2_load;
  logic        accept;
  logic [1:0]  k;
  logic        op_ok;
  logic        st;
  logic        misalign;
  logic        out_of_range;
  logic        fault;
  logic [3:0]  we_mask;
  logic [31:0] ld_data;

  assign s2_load   = s1_valid_q && (!s2_valid_q || resp_ready);
  assign req_ready = !reset && (!s1_valid_q || s2_load);
  // NOP is acknowledged but never enters the pipeline.
  assign accept    = req_valid && req_ready && (req_op != OP_NOP);

  assign k            = s1_addr_q[1:0];
  assign op_ok        = is_valid_op(s1_op_q);
  assign st           = op_ok && is_store(s1_op_q);
  assign out_of_range = |s1_addr_q[31:DM_ADDR_WIDTH];
  // Undefined op codes fault as loads (st is 0 for them).
  assign fault        = misalign || out_of_range || !op_ok;

  always_comb begin
    misalign = 1'b0;
    we_mask  = 4'b0000;
    dm_wdata = s1_wdata_q;
    case (s1_op_q)
      OP_LW:         misalign = (k != 2'd0);
      OP_LH, OP_LHU: misalign = k[0];
      OP_SW: begin
        misalign = (k != 2'd0);
        we_mask  = 4'b1111;
      end
      OP_SH: begin
        misalign = k[0];
        we_mask  = k[1] ? 4'b1100 : 4'b0011;
        dm_wdata = {2{s1_wdata_q[15:0]}};
      end
      OP_SB: begin
        we_mask  = 4'b0001 << k;
        dm_wdata = {4{s1_wdata_q[7:0]}};
      end
      default: ;
    endcase
  end

  // Write only in the cycle S1 advances, so a stalled store writes exactly once;
  // reset kills the strobe immediately.
  assign dm_we   = (s2_load && st && !fault && !reset) ? we_mask : 4'b0000;
  assign dm_addr = s1_addr_q[31:2];
  assign dm_pc   = s1_pc_q;

  dm_load_extend u_extend (
    .op_i   (s1_op_q),
    .off_i  (k),
    .word_i (dm_rdata),
    .data_o (ld_data)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept)       s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;

    s2_valid_d = s2_valid_q;
    if (s2_load)         s2_valid_d = 1'b1;
    else if (resp_ready) s2_valid_d = 1'b0;

    s2_rdata_d = (fault || st) ? 32'h0000_0000 : ld_data;
    s2_exc_d   = fault ? (st ? EXC_ADES : EXC_ADEL) : 5'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_rdata_q <= 32'h0000_0000;
      s2_exc_q   <= 5'd0;
      s2_pc_q    <= 32'h0000_0000;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        s2_rdata_q <= s2_rdata_d;
        s2_exc_q   <= s2_exc_d;
        s2_pc_q    <= s1_pc_q;
      end
    end
    // S1 payload needs no reset; it is qualified by s1_valid_q.
    if (accept) begin
      s1_op_q    <= req_op;
      s1_addr_q  <= req_addr;
      s1_wdata_q <= req_wdata;
      s1_pc_q    <= req_pc;
    end
  end

  assign resp_valid = s2_valid_q;
  assign resp_rdata = s2_rdata_q;
  assign resp_exc   = s2_exc_q;
  assign resp_pc    = s2_pc_q;

endmodule

// File: tb/tb_dm_access_unit.sv
module tb_dm_access_unit;
  import dm_access_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic [31:0] dm_pc;
  logic [29:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_we;
  logic [31:0] dm_rdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_exc;
  logic [31:0] resp_pc;

  always #5 clk = ~clk;

  dm_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_pc     (req_pc),
    .dm_pc      (dm_pc),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_we      (dm_we),
    .dm_rdata   (dm_rdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_exc   (resp_exc),
    .resp_pc    (resp_pc)
  );

  // Data memory model: 2048 words, combinational read, byte-masked write.
  logic [31:0] mem [0:2047];
  int          wr_cnt = 0;
  assign dm_rdata = mem[dm_addr[10:0]];

  always @(posedge clk) begin
    if (dm_we != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (dm_we[b]) mem[dm_addr[10:0]][8*b +: 8] = dm_wdata[8*b +: 8];
      wr_cnt = wr_cnt + 1;
    end
  end

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errs++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Called at a negedge; returns at the negedge after the request was taken.
  task automatic send(input logic [3:0] op, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] pc);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = data;
    req_pc    = pc;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        @(negedge clk);
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    fail_now("send_timeout");
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
    fail_now("resp_timeout");
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [4:0]  exp_exc;
    int          exp_wr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          w0;
    logic [31:0] b2b_exp [0:4];

    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[1]     = 32'hAAAA_AAAA;
    mem[16'h14] = 32'h600D_F00D;
    mem[11'h7FF] = 32'hCAFE_BABE;

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = OP_NOP;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_pc     = 32'h0;
    resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_exc", 32'(resp_exc), 32'h0);
    chk("rst_resp_pc", resp_pc, 32'h0);
    chk("rst_dm_we", 32'(dm_we), 32'h0);
    reset = 1'b0;

    // SB to 0x13: accepted this cycle, DM access next cycle, response after.
    req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h13; req_wdata = 32'hAB; req_pc = 32'h100;
    #1;
    chk("sb_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("sb_dm_addr", {2'b00, dm_addr}, 32'h4);
    chk("sb_dm_we", 32'(dm_we), 32'h8);
    chk("sb_dm_wdata", dm_wdata, 32'hABAB_ABAB);
    chk("sb_dm_pc", dm_pc, 32'h100);
    chk("sb_resp_early", 32'(resp_valid), 32'h0);
    @(negedge clk);
    chk("sb_resp_valid", 32'(resp_valid), 32'h1);
    chk("sb_resp_exc", 32'(resp_exc), 32'h0);
    chk("sb_resp_rdata", resp_rdata, 32'h0);
    chk("sb_resp_pc", resp_pc, 32'h100);
    @(negedge clk);
    chk("sb_resp_drain", 32'(resp_valid), 32'h0);
    chk("sb_mem", mem[4], 32'hAB00_0000);
    mem[4] = 32'h8000_F0FE;

    // NOP is reported ready but never produces a response.
    req_valid = 1'b1; req_op = OP_NOP; req_addr = 32'h10;
    #1;
    chk("nop_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("nop_no_resp", 32'(resp_valid), 32'h0);
    @(negedge clk);
    chk("nop_no_resp2", 32'(resp_valid), 32'h0);

    vecs.push_back('{OP_LB,   32'h10,   32'h0,         32'hFFFF_FFFE, 5'd0, 0});
    vecs.push_back('{OP_LBU,  32'h10,   32'h0,         32'h0000_00FE, 5'd0, 0});
    vecs.push_back('{OP_LH,   32'h12,   32'h0,         32'hFFFF_8000, 5'd0, 0});
    vecs.push_back('{OP_LHU,  32'h12,   32'h0,         32'h0000_8000, 5'd0, 0});
    vecs.push_back('{OP_LW,   32'h10,   32'h0,         32'h8000_F0FE, 5'd0, 0});
    vecs.push_back('{OP_LB,   32'h13,   32'h0,         32'hFFFF_FF80, 5'd0, 0});
    vecs.push_back('{OP_LBU,  32'h11,   32'h0,         32'h0000_00F0, 5'd0, 0});
    vecs.push_back('{OP_LH,   32'h10,   32'h0,         32'hFFFF_F0FE, 5'd0, 0});
    vecs.push_back('{OP_LW,   32'h1FFC, 32'h0,         32'hCAFE_BABE, 5'd0, 0});
    vecs.push_back('{OP_SW,   32'h22,   32'h1111_2222, 32'h0,         5'd5, 0});
    vecs.push_back('{OP_LH,   32'h31,   32'h0,         32'h0,         5'd4, 0});
    vecs.push_back('{OP_LW,   32'h2000, 32'h0,         32'h0,         5'd4, 0});
    vecs.push_back('{OP_SB,   32'h2001, 32'h77,        32'h0,         5'd5, 0});
    vecs.push_back('{4'd7,    32'h10,   32'h0,         32'h0,         5'd4, 0});
    vecs.push_back('{4'd12,   32'h10,   32'h5555_5555, 32'h0,         5'd4, 0});
    vecs.push_back('{OP_LHU,  32'h13,   32'h0,         32'h0,         5'd4, 0});
    vecs.push_back('{OP_SH,   32'h41,   32'h9999,      32'h0,         5'd5, 0});
    vecs.push_back('{OP_SW,   32'h40,   32'h1122_3344, 32'h0,         5'd0, 1});
    vecs.push_back('{OP_LW,   32'h40,   32'h0,         32'h1122_3344, 5'd0, 0});
    vecs.push_back('{OP_SH,   32'h42,   32'h0000_BEEF, 32'h0,         5'd0, 1});
    vecs.push_back('{OP_LW,   32'h40,   32'h0,         32'hBEEF_3344, 5'd0, 0});
    vecs.push_back('{OP_SB,   32'h41,   32'h55,        32'h0,         5'd0, 1});
    vecs.push_back('{OP_LW,   32'h40,   32'h0,         32'hBEEF_5544, 5'd0, 0});
    vecs.push_back('{OP_SH,   32'h40,   32'hFFFF_7777, 32'h0,         5'd0, 1});
    vecs.push_back('{OP_LW,   32'h40,   32'h0,         32'hBEEF_7777, 5'd0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      w0 = wr_cnt;
      send(vecs[i].op, vecs[i].addr, vecs[i].wdata, 32'h1000 + 32'(i * 4));
      wait_resp(ok);
      if (ok) begin
        chk($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
        chk($sformatf("v%0d_exc", i), 32'(resp_exc), 32'(vecs[i].exp_exc));
        chk($sformatf("v%0d_pc", i), resp_pc, 32'h1000 + 32'(i * 4));
      end
      @(negedge clk);
      chk($sformatf("v%0d_writes", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_wr));
    end

    // Back-to-back loads: one response per cycle, in order.
    b2b_exp[0] = 32'hFFFF_FFFE;
    b2b_exp[1] = 32'h0000_00FE;
    b2b_exp[2] = 32'hFFFF_8000;
    b2b_exp[3] = 32'h0000_8000;
    b2b_exp[4] = 32'h8000_F0FE;
    for (int i = 0; i < 8; i++) begin
      if (i >= 2 && i < 7) begin
        chk($sformatf("b2b%0d_valid", i - 2), 32'(resp_valid), 32'h1);
        chk($sformatf("b2b%0d_rdata", i - 2), resp_rdata, b2b_exp[i - 2]);
        chk($sformatf("b2b%0d_pc", i - 2), resp_pc, 32'h2000 + 32'((i - 2) * 4));
      end
      if (i == 7) chk("b2b_drain", 32'(resp_valid), 32'h0);
      if (i < 5) begin
        chk($sformatf("b2b%0d_ready", i), 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_pc    = 32'h2000 + 32'(i * 4);
        case (i)
          0: begin req_op = OP_LB;  req_addr = 32'h10; end
          1: begin req_op = OP_LBU; req_addr = 32'h10; end
          2: begin req_op = OP_LH;  req_addr = 32'h12; end
          3: begin req_op = OP_LHU; req_addr = 32'h12; end
          default: begin req_op = OP_LW; req_addr = 32'h10; end
        endcase
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Backpressure: a load fills S2, SH then waits in S1 until the stall clears.
    w0 = wr_cnt;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h10; req_wdata = 32'h0; req_pc = 32'h3000;
    #1;
    chk("st_ready0", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_op = OP_SH; req_addr = 32'h06; req_wdata = 32'h1234; req_pc = 32'h3004;
    #1;
    chk("st_ready1", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_op = OP_LW; req_addr = 32'h04; req_wdata = 32'h0; req_pc = 32'h3008;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("st_hold%0d_valid", i), 32'(resp_valid), 32'h1);
      chk($sformatf("st_hold%0d_rdata", i), resp_rdata, 32'h8000_F0FE);
      chk($sformatf("st_hold%0d_pc", i), resp_pc, 32'h3000);
      chk($sformatf("st_hold%0d_ready", i), 32'(req_ready), 32'h0);
      chk($sformatf("st_hold%0d_we", i), 32'(dm_we), 32'h0);
      @(negedge clk);
      #1;
    end
    resp_ready = 1'b1;
    #1;
    chk("st_release_we", 32'(dm_we), 32'hC);
    chk("st_release_addr", {2'b00, dm_addr}, 32'h1);
    chk("st_release_wdata", dm_wdata, 32'h1234_1234);
    chk("st_release_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    chk("st_sh_valid", 32'(resp_valid), 32'h1);
    chk("st_sh_pc", resp_pc, 32'h3004);
    chk("st_sh_exc", 32'(resp_exc), 32'h0);
    chk("st_sh_rdata", resp_rdata, 32'h0);
    chk("st_after_we", 32'(dm_we), 32'h0);
    req_op = OP_LBU; req_addr = 32'h13; req_pc = 32'h300C;
    #1;
    chk("st_ready_lbu", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("st_lw_pc", resp_pc, 32'h3008);
    chk("st_lw_rdata", resp_rdata, 32'h1234_AAAA);
    @(negedge clk);
    chk("st_lbu_pc", resp_pc, 32'h300C);
    chk("st_lbu_rdata", resp_rdata, 32'h0000_0080);
    @(negedge clk);
    chk("st_drain", 32'(resp_valid), 32'h0);
    chk("st_writes", 32'(wr_cnt - w0), 32'h1);
    chk("st_mem", mem[1], 32'h1234_AAAA);

    // Reset while a store sits in S1: the store is dropped.
    w0 = wr_cnt;
    req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h50; req_wdata = 32'hDEAD_BEEF; req_pc = 32'h4000;
    #1;
    chk("rs_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rs_we_forced", 32'(dm_we), 32'h0);
    chk("rs_ready_low", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("rs_resp_valid", 32'(resp_valid), 32'h0);
    chk("rs_resp_pc", resp_pc, 32'h0);
    chk("rs_resp_exc", 32'(resp_exc), 32'h0);
    chk("rs_resp_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h50; req_pc = 32'h4004;
    #1;
    chk("rs_post_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rs_post_valid", 32'(resp_valid), 32'h1);
    chk("rs_post_rdata", resp_rdata, 32'h600D_F00D);
    chk("rs_post_pc", resp_pc, 32'h4004);
    chk("rs_writes", 32'(wr_cnt - w0), 32'h0);
    chk("rs_mem", mem[16'h14], 32'h600D_F00D);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
